// File: rtl/lsu_align.sv
// RV32 load/store alignment in front of a 32-bit byte-masked memory; 1-3 cycles accept-to-resp_valid.
// req_ready is high only in IDLE; word-crossing accesses take two memory cycles or report an error.
module lsu_align #(
    parameter int ADDR_WIDTH       = 32,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_we,
    output logic [3:0]            mem_wmask,
    input  logic [31:0]           mem_rdata
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC0 = 2'd1;
    localparam logic [1:0] ST_ACC1 = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0]            state_q, state_d;
    logic                  we_q, we_d;
    logic [2:0]            f3_q, f3_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           b0_q, b0_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;

    function automatic logic [2:0] size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   size_of = 3'd1;
            2'b01:   size_of = 3'd2;
            default: size_of = 3'd4;
        endcase
    endfunction

    function automatic logic is_legal(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: is_legal = 1'b1;
            default:                                is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic crosses(input logic [1:0] off, input logic [2:0] size);
        crosses = ({1'b0, off} + size) > 3'd4;
    endfunction

    // Request-side decode, used only on the accept edge.
    logic       legal_in;
    logic       cross_in;
    logic       illegal_in;

    always_comb begin
        legal_in   = is_legal(req_funct3);
        cross_in   = crosses(req_addr[1:0], size_of(req_funct3));
        illegal_in = !legal_in || (!SPLIT_MISALIGNED && cross_in);
    end

    // Registered-request decode.
    logic [1:0]            off;
    logic [2:0]            size_q;
    logic                  cross_q;
    logic [7:0]            mask8;
    logic [4:0]            sh0;
    logic [5:0]            sh1;
    logic [ADDR_WIDTH-1:0] word_base;

    always_comb begin
        off       = addr_q[1:0];
        size_q    = size_of(f3_q);
        cross_q   = SPLIT_MISALIGNED && crosses(off, size_q);
        // Upper nibble of the shifted mask is exactly the second-word mask.
        mask8     = ((8'd1 << size_q) - 8'd1) << off;
        sh0       = {off, 3'b000};
        sh1       = 6'd32 - {1'b0, off, 3'b000};
        word_base = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    end

    // Load assembly: first word from buffer (or live data in ACC0), second word live in ACC1.
    logic [31:0] src0;
    logic [31:0] src1;
    logic [31:0] load_raw;
    logic [31:0] load_ext;

    always_comb begin
        src0     = (state_q == ST_ACC0) ? mem_rdata : b0_q;
        src1     = (state_q == ST_ACC1) ? mem_rdata : 32'd0;
        load_raw = (src0 >> sh0) | (src1 << sh1);
        case (f3_q)
            3'b000:  load_ext = {{24{load_raw[7]}}, load_raw[7:0]};
            3'b001:  load_ext = {{16{load_raw[15]}}, load_raw[15:0]};
            3'b100:  load_ext = {24'd0, load_raw[7:0]};
            3'b101:  load_ext = {16'd0, load_raw[15:0]};
            default: load_ext = load_raw;
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = 32'd0;
        mem_we    = 1'b0;
        mem_wmask = 4'd0;
        case (state_q)
            ST_ACC0: begin
                mem_addr = word_base;
                if (we_q) begin
                    mem_we    = 1'b1;
                    mem_wmask = mask8[3:0];
                    mem_wdata = wdata_q << sh0;
                end
            end
            ST_ACC1: begin
                mem_addr = word_base + ADDR_WIDTH'(4);
                if (we_q) begin
                    mem_we    = 1'b1;
                    mem_wmask = mask8[7:4];
                    mem_wdata = wdata_q >> sh1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        b0_d    = b0_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (illegal_in) begin
                        state_d = ST_RESP;
                        rdata_d = 32'd0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_ACC0;
                    end
                end
            end
            ST_ACC0: begin
                if (!we_q) begin
                    b0_d = mem_rdata;
                end
                if (cross_q) begin
                    state_d = ST_ACC1;
                end else begin
                    state_d = ST_RESP;
                    rdata_d = we_q ? 32'd0 : load_ext;
                    err_d   = 1'b0;
                end
            end
            ST_ACC1: begin
                state_d = ST_RESP;
                rdata_d = we_q ? 32'd0 : load_ext;
                err_d   = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            b0_q    <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            b0_q    <= b0_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_align.sv
// Randomized bench for lsu_align against a byte-level memory model, plus directed corner cases.
module tb_lsu_align;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [3:0]  mem_wmask;

    lsu_align #(.ADDR_WIDTH(32), .SPLIT_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    // Second instance with splitting disabled, fed from a constant memory word.
    logic        ns_req_valid, ns_req_ready, ns_req_we;
    logic [2:0]  ns_req_funct3;
    logic [31:0] ns_req_addr, ns_req_wdata;
    logic        ns_resp_valid, ns_resp_err;
    logic [31:0] ns_resp_rdata;
    logic [31:0] ns_mem_addr, ns_mem_wdata, ns_mem_rdata;
    logic        ns_mem_we;
    logic [3:0]  ns_mem_wmask;

    lsu_align #(.ADDR_WIDTH(32), .SPLIT_MISALIGNED(1'b0)) u_ns (
        .clk(clk), .rst(rst),
        .req_valid(ns_req_valid), .req_ready(ns_req_ready), .req_we(ns_req_we),
        .req_funct3(ns_req_funct3), .req_addr(ns_req_addr), .req_wdata(ns_req_wdata),
        .resp_valid(ns_resp_valid), .resp_rdata(ns_resp_rdata), .resp_err(ns_resp_err),
        .mem_addr(ns_mem_addr), .mem_wdata(ns_mem_wdata), .mem_we(ns_mem_we),
        .mem_wmask(ns_mem_wmask), .mem_rdata(ns_mem_rdata)
    );

    // Word memory seen by the DUT (1 KiB, address bits [9:2]).
    logic [31:0] mem [256];
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++)
                if (mem_wmask[i]) mem[mem_addr[9:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
    end

    // Reference: byte-addressed memory and a queue of expected per-cycle outputs.
    logic [7:0] ref_mem [1024];

    typedef struct {
        logic        rsp;
        logic        we;
        logic [3:0]  mask;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t q[$];

    int n_chk = 0;
    int n_err = 0;
    logic manual = 1'b1;
    logic [31:0] hold_rdata = 32'd0;
    logic        hold_err   = 1'b0;
    logic [31:0] obs_addr [2];
    logic [31:0] obs_wdata [2];
    logic [3:0]  obs_mask [2];
    int          obs_n = 0;
    logic [31:0] obs_rdata = 32'd0;
    logic        obs_err = 1'b0;
    logic [2:0]  legal_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, want 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    // Derive the expected bus activity from which bytes the access touches.
    function automatic void model(input logic we, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        int s;
        logic [31:0] val;
        logic [31:0] w0;
        e = '{rsp: 1'b1, we: 1'b0, mask: 4'd0, addr: 32'd0, wdata: 32'd0, rdata: 32'd0, err: 1'b0};
        if (!(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) begin
            e.err = 1'b1;
            q.push_back(e);
            return;
        end
        s  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        w0 = addr & ~32'd3;
        for (int k = 0; k < 2; k++) begin
            logic [31:0] wb;
            logic [31:0] ba;
            exp_t a;
            bit any;
            wb  = w0 + 32'(4 * k);
            a   = '{rsp: 1'b0, we: we, mask: 4'd0, addr: wb, wdata: 32'd0, rdata: 32'd0, err: 1'b0};
            any = 1'b0;
            for (int i = 0; i < s; i++) begin
                ba = addr + 32'(i);
                if ((ba & ~32'd3) == wb) begin
                    any = 1'b1;
                    if (we) begin
                        a.mask[ba[1:0]] = 1'b1;
                        a.wdata[8*ba[1:0] +: 8] = wd[8*i +: 8];
                    end
                end
            end
            if (any) q.push_back(a);
        end
        val = 32'd0;
        for (int i = 0; i < s; i++) begin
            logic [31:0] ba;
            ba = addr + 32'(i);
            if (we) ref_mem[ba[9:0]] = wd[8*i +: 8];
            else    val[8*i +: 8] = ref_mem[ba[9:0]];
        end
        if (f3 == 3'b000) val = {{24{val[7]}}, val[7:0]};
        if (f3 == 3'b001) val = {{16{val[15]}}, val[15:0]};
        e.rdata = we ? 32'd0 : val;
        q.push_back(e);
    endfunction

    exp_t ce;
    always @(negedge clk) begin
        if (!rst && !manual) begin
            if (q.size() > 0) begin
                ce = q.pop_front();
                chk("req_ready_busy", req_ready, 1'b0);
                if (ce.rsp) begin
                    chk("resp_valid", resp_valid, 1'b1);
                    chk("resp_err", resp_err, ce.err);
                    chk("resp_rdata", resp_rdata, ce.rdata);
                    chk("resp_mem_we", mem_we, 1'b0);
                    chk("resp_mem_addr", mem_addr, 32'd0);
                    hold_rdata = ce.rdata;
                    hold_err   = ce.err;
                    obs_rdata  = resp_rdata;
                    obs_err    = resp_err;
                end else begin
                    chk("acc_resp_valid", resp_valid, 1'b0);
                    chk("mem_we", mem_we, ce.we);
                    chk("mem_wmask", mem_wmask, ce.mask);
                    chk("mem_addr", mem_addr, ce.addr);
                    if (ce.we) chk("mem_wdata", mem_wdata & lanes(ce.mask), ce.wdata);
                    if (obs_n < 2) begin
                        obs_addr[obs_n]  = mem_addr;
                        obs_wdata[obs_n] = mem_wdata;
                        obs_mask[obs_n]  = mem_wmask;
                        obs_n++;
                    end
                end
            end else begin
                chk("idle_req_ready", req_ready, 1'b1);
                chk("idle_resp_valid", resp_valid, 1'b0);
                chk("idle_mem_we", mem_we, 1'b0);
                chk("idle_mem_wmask", mem_wmask, 4'd0);
                chk("idle_mem_addr", mem_addr, 32'd0);
                chk("idle_mem_wdata", mem_wdata, 32'd0);
                chk("hold_rdata", resp_rdata, hold_rdata);
                chk("hold_err", resp_err, hold_err);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int early);
        int t;
        logic r;
        t = 0;
        while (q.size() > (early != 0 ? 1 : 0) && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 50) chk("drain_timeout", 1'b1, 1'b0);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        t = 0;
        do begin
            @(negedge clk); r = req_ready;
            @(posedge clk); t++;
        end while (!r && t < 50);
        #1 req_valid = 1'b0;
        if (!r) chk("accept_timeout", 1'b1, 1'b0);
        else begin
            obs_n = 0;
            model(we, f3, addr, wd);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() > 0 && t < 50) begin
            @(posedge clk); t++;
        end
        if (t >= 50) chk("drain_timeout", 1'b1, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic ns_run(input logic [2:0] f3, input logic [31:0] addr, input logic exp_err,
                          input logic [31:0] exp_rd, input int exp_lat);
        int lat;
        bit got;
        ns_req_valid = 1'b1; ns_req_we = 1'b0; ns_req_funct3 = f3;
        ns_req_addr = addr; ns_req_wdata = 32'd0;
        @(posedge clk); #1 ns_req_valid = 1'b0;
        lat = 0; got = 1'b0;
        while (!got && lat < 6) begin
            @(negedge clk); lat++;
            chk("ns_mem_we", ns_mem_we, 1'b0);
            if (exp_err) chk("ns_mem_addr", ns_mem_addr, 32'd0);
            if (ns_resp_valid) begin
                got = 1'b1;
                chk("ns_latency", lat, exp_lat);
                chk("ns_resp_err", ns_resp_err, exp_err);
                chk("ns_resp_rdata", ns_resp_rdata, exp_rd);
            end
        end
        if (!got) chk("ns_resp_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
    endtask

    logic [31:0] pre20, pre24;
    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        ns_req_valid = 1'b0; ns_req_we = 1'b0; ns_req_funct3 = 3'd0;
        ns_req_addr = 32'd0; ns_req_wdata = 32'd0;
        ns_mem_rdata = 32'h12345678;
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = mem[i][8*b +: 8];
        end
        #3;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", resp_err, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_wmask", mem_wmask, 4'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        manual = 1'b0;

        issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0); drain();
        chk("sw_n", obs_n, 1); chk("sw_addr", obs_addr[0], 32'h10);
        chk("sw_mask", obs_mask[0], 4'hF); chk("sw_wdata", obs_wdata[0], 32'hDEADBEEF);
        chk("sw_err", obs_err, 1'b0);
        issue(1'b0, 3'b010, 32'h10, 32'd0, 0); drain();
        chk("lw_rdata", obs_rdata, 32'hDEADBEEF);

        issue(1'b1, 3'b000, 32'h13, 32'h000000A5, 0); drain();
        chk("sb_mask", obs_mask[0], 4'b1000); chk("sb_wdata", obs_wdata[0], 32'hA5000000);
        issue(1'b0, 3'b000, 32'h13, 32'd0, 0); drain();
        chk("lb_rdata", obs_rdata, 32'hFFFFFFA5);
        issue(1'b0, 3'b100, 32'h13, 32'd0, 0); drain();
        chk("lbu_rdata", obs_rdata, 32'h000000A5);

        issue(1'b1, 3'b010, 32'h22, 32'h11223344, 0); drain();
        chk("swx_n", obs_n, 2);
        chk("swx_addr0", obs_addr[0], 32'h20); chk("swx_mask0", obs_mask[0], 4'b1100);
        chk("swx_wdata0", obs_wdata[0], 32'h33440000);
        chk("swx_addr1", obs_addr[1], 32'h24); chk("swx_mask1", obs_mask[1], 4'b0011);
        chk("swx_wdata1", obs_wdata[1], 32'h00001122);
        issue(1'b0, 3'b010, 32'h22, 32'd0, 0); drain();
        chk("lwx_rdata", obs_rdata, 32'h11223344);

        issue(1'b1, 3'b010, 32'h24, 32'h80000000, 0);
        issue(1'b1, 3'b010, 32'h28, 32'h00000092, 1);
        issue(1'b0, 3'b001, 32'h27, 32'd0, 1); drain();
        chk("lhx_rdata", obs_rdata, 32'hFFFF9280);
        issue(1'b0, 3'b101, 32'h27, 32'd0, 0); drain();
        chk("lhux_rdata", obs_rdata, 32'h00009280);
        issue(1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000BEEF, 0); drain();
        chk("shwrap_addr0", obs_addr[0], 32'hFFFFFFFC); chk("shwrap_mask0", obs_mask[0], 4'b1000);
        chk("shwrap_addr1", obs_addr[1], 32'h00000000); chk("shwrap_mask1", obs_mask[1], 4'b0001);
        issue(1'b0, 3'b001, 32'h21, 32'd0, 0); drain();
        chk("lh_o1_n", obs_n, 1);

        issue(1'b0, 3'b011, 32'h40, 32'd0, 0); drain();
        chk("ill_err", obs_err, 1'b1); chk("ill_rdata", obs_rdata, 32'd0); chk("ill_n", obs_n, 0);

        for (int n = 0; n < 400; n++) begin
            logic [2:0] f3;
            logic [31:0] a;
            int r;
            r  = $urandom_range(0, 19);
            f3 = (r == 0) ? 3'b011 : (r == 1) ? 3'b110 : (r == 2) ? 3'b111
                                   : legal_f3[$urandom_range(0, 4)];
            a  = ($urandom_range(0, 9) == 0) ? (32'hFFFFFC00 | 32'($urandom_range(0, 1023)))
                                             : 32'($urandom_range(0, 1023));
            issue(1'($urandom_range(0, 1)), f3, a, $urandom, $urandom_range(0, 1));
        end
        drain();

        // Reset in the second half of a crossing store.
        manual = 1'b1;
        pre20 = mem[8]; pre24 = mem[9];
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h22; req_wdata = 32'h11223344;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #2;
        chk("rst_acc1_we_before", mem_we, 1'b1);
        rst = 1'b1; #1;
        chk("rst_acc1_we", mem_we, 1'b0);
        chk("rst_acc1_mask", mem_wmask, 4'd0);
        chk("rst_acc1_resp", resp_valid, 1'b0);
        repeat (2) begin
            @(negedge clk); chk("rst_no_resp", resp_valid, 1'b0);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_after_ready", req_ready, 1'b1);
        chk("rst_after_resp", resp_valid, 1'b0);
        chk("rst_word20", mem[8], {16'h3344, pre20[15:0]});
        chk("rst_word24", mem[9], pre24);
        ref_mem[10'h22] = 8'h44; ref_mem[10'h23] = 8'h33;
        hold_rdata = 32'd0; hold_err = 1'b0;
        manual = 1'b0;
        @(posedge clk); #1;
        issue(1'b0, 3'b010, 32'h20, 32'd0, 0);
        issue(1'b0, 3'b010, 32'h24, 32'd0, 0); drain();

        ns_run(3'b010, 32'h22, 1'b1, 32'd0, 1);
        ns_run(3'b010, 32'h20, 1'b0, 32'h12345678, 2);
        ns_run(3'b001, 32'h21, 1'b0, 32'h00003456, 2);
        ns_run(3'b001, 32'h23, 1'b1, 32'd0, 1);

        for (int n = 0; n < 50; n++)
            issue(1'($urandom_range(0, 1)), legal_f3[$urandom_range(0, 4)],
                  32'($urandom_range(0, 1023)), $urandom, 0);
        drain();
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_align.md
Name: lsu_align

Overview:
- Load/store alignment unit directly upstream of the 32-bit byte-masked data memory port; this unit drives address, write data, write enable and 4-bit write mask, and the memory returns read data combinationally.
- Accepts one RV32 load/store per handshake.
- Generates byte masks and shifted store data.
- Extracts and sign/zero-extends load data.
- Splits word-crossing misaligned accesses into two sequential memory cycles.

Parameters:
- ADDR_WIDTH, 32, width of byte addresses (req_addr, mem_addr).
- SPLIT_MISALIGNED, 1: 1 = split word-crossing accesses into two cycles; 0 = flag them as errors with no memory access.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; all other codes are illegal.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  illegal funct3, or crossing access with SPLIT_MISALIGNED=0.
- mem_addr  out  ADDR_WIDTH  word-aligned byte address; bits [1:0] always 0.
- mem_wdata  out  32  byte-lane-positioned store data.
- mem_we  out  1  write enable; memory writes at the rising edge.
- mem_wmask  out  4  byte lane enables; bit i = bits [8i+7:8i].
- mem_rdata  in  32  combinational read data for mem_addr in the same cycle.

Behaviour:
- Reset values:
  - State IDLE.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_we=0, mem_wmask=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation: mem_we drops immediately on rst assertion. No response is produced. A first-half store already written stays in memory; there is no rollback.
- FSM states: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - On req_valid && req_ready, register we, funct3, addr and wdata.
  - Compute size S (1/2/4) and offset o = addr[1:0].
  - Illegal request → RESP.
  - Otherwise → ACC0.
- Crossing condition: o+S>4. With SPLIT_MISALIGNED=0, a crossing request is illegal.
- ACC0:
  - mem_addr = {addr[ADDR_WIDTH-1:2],2'b00}.
  - Store:
    - mem_wdata = wdata<<(8o).
    - mem_wmask = ((1<<S)-1)<<o, truncated to 4 bits.
    - mem_we = 1.
  - Load: mem_we=0, mem_wmask=0; latch mem_rdata into buffer B0.
  - Crossing access → ACC1, otherwise → RESP.
- ACC1:
  - mem_addr = ACC0 address + 4, modulo 2^ADDR_WIDTH (0xFFFFFFFC wraps to 0x00000000).
  - Store:
    - mem_wdata = wdata>>(8(4-o)).
    - mem_wmask = (1<<(o+S-4))-1.
    - mem_we = 1.
  - Load: latch mem_rdata into buffer B1.
  - Always → RESP.
- Load assembly: raw = (B0>>(8o)) | (crossing ? B1<<(8(4-o)) : 0).
  - B/H: sign-extend raw[7:0] or raw[15:0].
  - BU/HU: zero-extend.
  - W: raw.
  - Result is registered into resp_rdata on entry to RESP.
- RESP: resp_valid=1 for exactly one cycle, with resp_err and resp_rdata held. Next state IDLE.
- Outside RESP, resp_valid=0. resp_rdata and resp_err hold their last values.
- Outside ACC0/ACC1: mem_we=0, mem_wmask=0, mem_addr=0, mem_wdata=0.
- Latency (accept edge at cycle T):
  - Error: resp_valid at T+1.
  - Aligned, or misaligned within one word: access at T+1, resp_valid at T+2.
  - Crossing: accesses at T+1 and T+2, resp_valid at T+3.
- Throughput: req_ready is low from ACC0 through RESP. No new request is accepted while a response pulses; requests are never dropped or overlapped.
- Halfword at o=1 is a single access: mask 0110, no split.

Test Plan:
1. SW addr 0x10, data 0xDEADBEEF → T+1: mem_we=1, mem_addr=0x10, mask=1111, wdata=0xDEADBEEF; resp_valid at T+2, err=0. Then LW 0x10 → resp_rdata=0xDEADBEEF at T+2.
2. SB addr 0x13, data 0x000000A5 → mask=1000, wdata=0xA5000000. Then LB 0x13 → 0xFFFFFFA5 and LBU 0x13 → 0x000000A5.
3. SW addr 0x22, data 0x11223344 → ACC0: addr 0x20, mask 1100, wdata 0x33440000; ACC1: addr 0x24, mask 0011, wdata 0x00001122; resp_valid at T+3. Then LW 0x22 → 0x11223344.
4. Memory word 0x24=0x80000000, word 0x28=0x00000092; LH 0x27 → 0xFFFF9280 and LHU 0x27 → 0x00009280, resp_valid at T+3. SH 0xFFFFFFFF → ACC1 mem_addr=0x00000000, mask 0001.
5. funct3=011 at addr 0x40 → no mem_we pulse, resp_valid at T+1, resp_err=1, resp_rdata=0. SPLIT_MISALIGNED=0 with LW 0x22 → same error response, mem_addr stays 0.
6. Assert rst during ACC1 of SW 0x22 → mem_we=0 within the same cycle, no resp_valid. Word 0x20 holds 0x3344 in its upper half, word 0x24 is unchanged, and req_ready=1 after rst deasserts.
